postadder_mt: RTL and testbench
===============================

# postadder_mt

Parametrised multi-thread, multi-accumulator post-adder for the redundant-form Fp datapath, the successor of the fixed 4-thread/3-accumulator post-adder. It sits after the multiplier reduction stage. It takes one redundant polynomial per cycle with a valid qualifier and updates NACC independent accumulator banks, each THREADS×DEPTH entries deep, with per-bank add/sub/load/clear modes. It returns one selected bank result two cycles later with a matching valid and sticky per-bank overflow flags.

## Interface
- LIMBS, 4: number of limbs per element (ADD_DIV).
- LIMB_W, 64: value bits per limb.
- CIN_W, 1: carry bits per limb on the input (L1 form).
- CARRY_W, 8: carry bits per limb in accumulators and output (L3 form).
- NACC, 3: number of accumulator banks.
- THREADS, 4: thread contexts per bank.
- DEPTH, 3: entries per thread per bank.
- MOD, PARAMS_BN254_d0::Mod: LIMBS*LIMB_W-bit modulus constant used by mode NEG.
- Derived: TW = max(1,clog2(THREADS)), AW = max(1,clog2(DEPTH)), EW = LIMB_W+CARRY_W, SW = NACC>1 ? clog2(NACC) : 1.
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  qualifies all inputs below for this cycle.
- in_data  in  LIMBS*(LIMB_W+CIN_W)  limb i = {carry,val} at bits [i*(LIMB_W+CIN_W) +: LIMB_W+CIN_W].
- mode  in  NACC*3  3-bit mode per bank.
- addr  in  NACC*AW  entry index per bank.
- thread  in  TW  thread context, shared by all banks.
- outsel  in  SW  bank whose result is returned.
- dout  out  LIMBS*EW  selected result, limb i = {carry,val}.
- dout_valid  out  1  dout qualifier.
- ovf  out  NACC  sticky overflow per bank.

## Operation
- Input zero-extends per limb: carry CIN_W→CARRY_W; val unchanged. MOD is split into limbs with carry 0.
- Limb arithmetic: each limb is an EW-bit two's-complement number F = carry·2^LIMB_W + val. Z = X ± Y is computed per limb modulo 2^EW. There is no inter-limb carry propagation.
- For bank k, R = entry[k][thread][addr_k] and I = converted input.
- Modes:
  - 000 NOP: no write; result = R.
  - 001 LOAD: write I.
  - 010 ADD: write I+R.
  - 011 SUB: write I−R.
  - 100 RSUB: write R−I.
  - 101 NEG: write MOD−R.
  - 110 CLR: write 0 and clear ovf[k].
  - 111 ADD: same as 010.
- Writes and ovf updates happen only when in_valid=1. When in_valid=0, no state changes except the output pipeline.
- Out-of-range addr_k (≥DEPTH) or thread (≥THREADS): R reads as 0 and the write is suppressed. The result still flows to the output.
- ovf[k] is set when any limb's true signed result of ADD/SUB/RSUB/NEG falls outside the EW-bit signed range. It stays set until CLR on bank k or reset.
- Banks are fully independent. Several banks may target the same addr/thread in one cycle without interaction.

## Timing
- Stage 1, the edge ending input cycle t:
  - bank write.
  - result_k → dly_k for every bank.
  - in_valid → v1.
  - outsel → sel1.
- Stage 2, edge t+1: dout ← dly[sel1] (zero if sel1 ≥ NACC); dout_valid ← v1. Latency is 2 cycles, throughput 1 per cycle, and there is no stall.
- Read-after-write: an entry written at edge t is the R seen by an input at cycle t+1. Back-to-back accumulation to one entry is correct with no bubble.
- dout holds its last value while dout_valid=0.
- Reset, asynchronous, effective immediately, any cycle:
  - all entries = 0.
  - dly, dout = 0.
  - dout_valid, v1 = 0.
  - ovf = 0.
- In-flight results are discarded. The first valid output after reset release comes 2 cycles after the first accepted input.

## Test plan
- Default params. LOAD bank0 t0 a0 with all limbs {0,5}, then ADD {0,7} next cycle, outsel=0. Required: dout all limbs {0,5} at t+2, then {0,12} at t+3, dout_valid high both cycles.
- SUB then RSUB, bank1 a2, t3. Store 10, SUB with I=3 → limbs 3−10 = −7 (carry 8'hFF, val 2^64−7). Then RSUB with I=1 on that entry → −8 (carry 8'hFF, val 2^64−8).
- NEG bank2 a0 holding 0 → MOD limbs with carry 0. Repeat 300 ADDs of carry-max {1,2^64−1} per limb → ovf[k] sets once the carry field crosses +127 and stays set. CLR clears both the entry and ovf.
- Thread isolation, same addr in threads 0–3: LOAD 1, 2, 3, 4 into each, then NOP reads with outsel cycling 0..2 → each thread returns its own value. in_valid=0 cycles leave the entries unchanged.
- Out-of-range addr=3 with DEPTH=3 and ADD I=9 → dout=9 and no entry modified. Also outsel=3 with NACC=3 → dout=0.
- Assert rstn low between two valid inputs → dout, dout_valid, ovf drop to 0 immediately. After release, an entry previously loaded to 5 reads 0.

Source files
------------

// File: rtl/postadder_mt.sv
// postadder_mt
//   Multi-thread, multi-bank post-adder for the redundant-form Fp datapath.
//   It takes one redundant polynomial per cycle. Every bank k reads its entry
//   R = ent[thread][addr_k], applies its own 3-bit mode against the converted
//   input I, and, when the cycle is valid, writes the result back. The result
//   of the bank chosen by outsel appears on dout two cycles after the input.
//
//   Limb arithmetic is EW-bit two's complement (carry:val) with no carry
//   between limbs. ovf[k] is sticky and is cleared only by CLR or by reset.
//
// Ports
//   clk         clock
//   rstn        asynchronous active-low reset
//   in_valid    qualifies in_data/mode/addr/thread/outsel for this cycle
//   in_data     LIMBS x {carry[CIN_W], val[LIMB_W]} input (L1 form)
//   mode        3-bit mode per bank (bank k at [k*3 +: 3])
//   addr        entry index per bank (bank k at [k*AW +: AW])
//   thread      thread context, shared by all banks
//   outsel      bank whose result is returned
//   dout        LIMBS x {carry[CARRY_W], val[LIMB_W]} selected result (L3 form)
//   dout_valid  dout qualifier
//   ovf         sticky per-bank overflow
//
// Handshake: valid-only. in_valid marks a cycle whose inputs are consumed at
// the next rising edge. There is no ready and no backpressure. dout_valid
// follows in_valid by exactly two cycles, and dout holds while dout_valid is 0.
module postadder_mt #(
  parameter int LIMBS   = 4,
  parameter int LIMB_W  = 64,
  parameter int CIN_W   = 1,
  parameter int CARRY_W = 8,
  parameter int NACC    = 3,
  parameter int THREADS = 4,
  parameter int DEPTH   = 3,
  parameter logic [LIMBS*LIMB_W-1:0] MOD =
    256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47,
  localparam int TW = (THREADS > 1) ? $clog2(THREADS) : 1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int EW = LIMB_W + CARRY_W,
  localparam int SW = (NACC > 1) ? $clog2(NACC) : 1,
  localparam int IW = LIMB_W + CIN_W,
  localparam int DW = LIMBS * EW
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic [LIMBS*IW-1:0]   in_data,
  input  logic [NACC*3-1:0]     mode,
  input  logic [NACC*AW-1:0]    addr,
  input  logic [TW-1:0]         thread,
  input  logic [SW-1:0]         outsel,
  output logic [DW-1:0]         dout,
  output logic                  dout_valid,
  output logic [NACC-1:0]       ovf
);

  localparam logic [2:0] M_NOP  = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SUB  = 3'b011;
  localparam logic [2:0] M_RSUB = 3'b100;
  localparam logic [2:0] M_NEG  = 3'b101;
  localparam logic [2:0] M_CLR  = 3'b110;

  // Thread range check. When THREADS fills the index space every value is in range.
  logic thr_ok;
  if (THREADS == (1 << TW)) begin : g_thr_full
    assign thr_ok = 1'b1;
  end else begin : g_thr_part
    assign thr_ok = (thread < TW'(THREADS));
  end

  logic [NACC*DW-1:0] dly_flat;

  for (genvar k = 0; k < NACC; k++) begin : g_bank
    logic [2:0]       m;
    logic [AW-1:0]    a;
    logic             a_ok;
    logic             hit_ok;
    logic [DW-1:0]    r;
    logic [DW-1:0]    in_ext;
    logic [DW-1:0]    arith;
    logic [DW-1:0]    res;
    logic [DW-1:0]    dly;
    logic [LIMBS-1:0] lovf;
    logic             do_wr;
    logic             is_arith;
    logic             sub;
    logic             swap;
    logic             use_mod;
    logic             ovf_r;
    logic [DW-1:0]    ent [THREADS][DEPTH];

    assign m = mode[k*3 +: 3];
    assign a = addr[k*AW +: AW];

    if (DEPTH == (1 << AW)) begin : g_addr_full
      assign a_ok = 1'b1;
    end else begin : g_addr_part
      assign a_ok = (a < AW'(DEPTH));
    end

    // An out-of-range access reads as zero and does not write, but its result
    // still goes down the output pipeline.
    assign hit_ok = a_ok & thr_ok;
    assign r      = hit_ok ? ent[thread][a] : '0;

    // Mode decode. The controls steer the single per-limb adder.
    always_comb begin
      do_wr    = 1'b1;
      is_arith = 1'b0;
      sub      = 1'b0;
      swap     = 1'b0;
      use_mod  = 1'b0;
      case (m)
        M_NOP:   do_wr = 1'b0;
        M_LOAD:  ;
        M_SUB:   begin is_arith = 1'b1; sub = 1'b1; end
        M_RSUB:  begin is_arith = 1'b1; sub = 1'b1; swap = 1'b1; end
        M_NEG:   begin is_arith = 1'b1; sub = 1'b1; use_mod = 1'b1; end
        M_CLR:   ;
        default: is_arith = 1'b1;  // 010 and 111 both add
      endcase
    end

    always_comb begin
      res = r;
      if (m == M_LOAD)     res = in_ext;
      else if (m == M_CLR) res = '0;
      else if (is_arith)   res = arith;
    end

    for (genvar i = 0; i < LIMBS; i++) begin : g_limb
      logic [EW-1:0] iv;
      logic [EW-1:0] rv;
      logic [EW-1:0] mv;
      logic [EW-1:0] x;
      logic [EW-1:0] y;
      logic [EW:0]   sum;

      assign iv = EW'(in_data[i*IW +: IW]);  // zero-extends the carry field
      assign rv = r[i*EW +: EW];
      assign mv = EW'(MOD[i*LIMB_W +: LIMB_W]);
      assign x  = use_mod ? mv : (swap ? rv : iv);
      assign y  = swap ? iv : rv;
      // Both operands are sign-extended by one bit. The top two bits of sum
      // differ exactly when the true signed result does not fit in EW bits.
      assign sum = {x[EW-1], x} + ({y[EW-1], y} ^ {(EW+1){sub}}) + (EW+1)'(sub);

      assign in_ext[i*EW +: EW] = iv;
      assign arith[i*EW +: EW]  = sum[EW-1:0];
      assign lovf[i]            = sum[EW] ^ sum[EW-1];
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int t = 0; t < THREADS; t++) begin
          for (int d = 0; d < DEPTH; d++) begin
            ent[t][d] <= '0;
          end
        end
        dly   <= '0;
        ovf_r <= 1'b0;
      end else begin
        dly <= res;
        if (in_valid) begin
          if (do_wr && hit_ok) ent[thread][a] <= res;
          if (m == M_CLR)                 ovf_r <= 1'b0;
          else if (is_arith && (|lovf))   ovf_r <= 1'b1;
        end
      end
    end

    assign dly_flat[k*DW +: DW] = dly;
    assign ovf[k]               = ovf_r;
  end

  // Output stage. A bank select past NACC-1 returns zero.
  logic          v1;
  logic [SW-1:0] sel1;
  logic [DW-1:0] sel_data;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NACC; k++) begin
      if (sel1 == SW'(k)) sel_data = dly_flat[k*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1         <= 1'b0;
      sel1       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      v1         <= in_valid;
      sel1       <= outsel;
      dout_valid <= v1;
      if (v1) dout <= sel_data;
    end
  end

endmodule

// File: tb/tb_postadder_mt.sv
module tb_postadder_mt;

  localparam int LIMBS   = 4;
  localparam int LIMB_W  = 64;
  localparam int CIN_W   = 1;
  localparam int CARRY_W = 8;
  localparam int NACC    = 3;
  localparam int THREADS = 4;
  localparam int DEPTH   = 3;
  localparam int TW = 2;
  localparam int AW = 2;
  localparam int SW = 2;
  localparam int EW = LIMB_W + CARRY_W;
  localparam int IW = LIMB_W + CIN_W;
  localparam int DW = LIMBS * EW;
  localparam logic [LIMBS*LIMB_W-1:0] MOD_C =
    256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
  localparam logic signed [79:0] SMAX = (80'sd1 <<< (EW - 1)) - 80'sd1;
  localparam logic signed [79:0] SMIN = -(80'sd1 <<< (EW - 1));

  localparam int M_NOP = 0, M_LOAD = 1, M_ADD = 2, M_SUB = 3, M_RSUB = 4,
                 M_NEG = 5, M_CLR = 6, M_ADD2 = 7;

  // ---------------- clock / reset ----------------
  logic                clk;
  logic                rstn;
  logic                in_valid;
  logic [LIMBS*IW-1:0] in_data;
  logic [NACC*3-1:0]   mode;
  logic [NACC*AW-1:0]  addr;
  logic [TW-1:0]       thread;
  logic [SW-1:0]       outsel;
  logic [DW-1:0]       dout;
  logic                dout_valid;
  logic [NACC-1:0]     ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  postadder_mt dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .mode       (mode),
    .addr       (addr),
    .thread     (thread),
    .outsel     (outsel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .ovf        (ovf)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Reference model: each entry holds plain limb values; results are evaluated
  // as wide signed integers and range-checked against the EW-bit signed range.
  logic [EW-1:0]     m_ent [NACC][THREADS][DEPTH][LIMBS];
  logic [NACC-1:0]   m_ovf;
  logic [DW:0]       exp_q[$];  // {valid, selected result} per input cycle
  logic [DW-1:0]     exp_dout;
  logic              exp_valid;
  logic [LIMBS*LIMB_W-1:0] mod_v;

  function automatic logic signed [79:0] sx(input logic [EW-1:0] x);
    return {{(80-EW){x[EW-1]}}, x};
  endfunction

  function automatic logic [LIMBS*IW-1:0] rep_in(input logic c, input logic [LIMB_W-1:0] v);
    logic [LIMBS*IW-1:0] d;
    for (int i = 0; i < LIMBS; i++) d[i*IW +: IW] = {c, v};
    return d;
  endfunction

  function automatic logic [DW-1:0] rep_out(input logic [CARRY_W-1:0] c, input logic [LIMB_W-1:0] v);
    logic [DW-1:0] d;
    for (int i = 0; i < LIMBS; i++) d[i*EW +: EW] = {c, v};
    return d;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NACC; k++)
      for (int t = 0; t < THREADS; t++)
        for (int d = 0; d < DEPTH; d++)
          for (int i = 0; i < LIMBS; i++) m_ent[k][t][d][i] = '0;
    m_ovf = '0;
    exp_q.delete();
    exp_dout  = '0;
    exp_valid = 1'b0;
  endtask

  task automatic model_cycle();
    logic [DW-1:0]      sel_res;
    logic [DW-1:0]      res;
    logic signed [79:0] rv, iv, mv, z;
    logic [IW-1:0]      il;
    logic [LIMB_W-1:0]  ml;
    int md, a, t;
    bit ok, hit;
    sel_res = '0;
    t = int'(thread);
    for (int k = 0; k < NACC; k++) begin
      md  = int'(mode[k*3 +: 3]);
      a   = int'(addr[k*AW +: AW]);
      ok  = (a < DEPTH) && (t < THREADS);
      hit = 0;
      res = '0;
      for (int i = 0; i < LIMBS; i++) begin
        rv = 80'sd0;
        if (ok) rv = sx(m_ent[k][t][a][i]);
        il = in_data[i*IW +: IW];
        iv = 80'(il);
        ml = mod_v[i*LIMB_W +: LIMB_W];
        mv = 80'(ml);
        case (md)
          M_NOP:         z = rv;
          M_LOAD:        z = iv;
          M_SUB:         z = iv - rv;
          M_RSUB:        z = rv - iv;
          M_NEG:         z = mv - rv;
          M_CLR:         z = 80'sd0;
          default:       z = iv + rv;
        endcase
        if (!(md inside {M_NOP, M_LOAD, M_CLR}) && (z > SMAX || z < SMIN)) hit = 1;
        res[i*EW +: EW] = z[EW-1:0];
      end
      if (in_valid) begin
        if (ok && md != M_NOP)
          for (int i = 0; i < LIMBS; i++) m_ent[k][t][a][i] = res[i*EW +: EW];
        if (md == M_CLR) m_ovf[k] = 1'b0;
        else if (hit)    m_ovf[k] = 1'b1;
      end
      if (int'(outsel) == k) sel_res = res;
    end
    exp_q.push_back({in_valid, sel_res});
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    in_valid = 1'b1;
    in_data  = '0;
    mode     = '0;
    addr     = '0;
    thread   = '0;
    outsel   = '0;
  endtask

  task automatic setb(input int k, input int m, input int a);
    mode[k*3 +: 3]  = 3'(m);
    addr[k*AW +: AW] = AW'(a);
  endtask

  // One clock: model evaluates the current inputs, the edge happens, and the
  // outputs are compared on the following falling edge.
  task automatic tick();
    logic [DW:0] e;
    model_cycle();
    @(posedge clk);
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      exp_valid = e[DW];
      if (e[DW]) exp_dout = e[DW-1:0];
    end else begin
      exp_valid = 1'b0;
    end
    @(negedge clk);
    check_eq("dout", dout, exp_dout);
    check_eq("dout_valid", DW'(dout_valid), DW'(exp_valid));
    check_eq("ovf", DW'(ovf), DW'(m_ovf));
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] mod_out;
  logic [LIMB_W-1:0] all1;
  logic [LIMB_W-1:0] rv64;

  initial begin
    mod_v = MOD_C;
    all1  = '1;
    for (int i = 0; i < LIMBS; i++) mod_out[i*EW +: EW] = {8'h00, mod_v[i*LIMB_W +: LIMB_W]};
    model_reset();
    rstn = 1'b0;
    idle();
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_dout", dout, '0);
    check_eq("rst_valid", DW'(dout_valid), '0);
    check_eq("rst_ovf", DW'(ovf), '0);
    rstn = 1'b1;
    @(negedge clk);

    // LOAD 5 then ADD 7 on bank0 t0 a0
    idle(); setb(0, M_LOAD, 0); in_data = rep_in(1'b0, 64'd5); tick();
    idle(); setb(0, M_ADD, 0);  in_data = rep_in(1'b0, 64'd7); tick();
    check_eq("load5", dout, rep_out(8'h00, 64'd5));
    idle(); in_valid = 1'b0; tick();
    check_eq("add12", dout, rep_out(8'h00, 64'd12));
    check_eq("add12_v", DW'(dout_valid), DW'(1));
    tick();

    // SUB then RSUB on bank1 a2 t3
    idle(); thread = 2'd3; outsel = 2'd1; setb(1, M_LOAD, 2); in_data = rep_in(1'b0, 64'd10); tick();
    idle(); thread = 2'd3; outsel = 2'd1; setb(1, M_SUB, 2);  in_data = rep_in(1'b0, 64'd3);  tick();
    idle(); thread = 2'd3; outsel = 2'd1; setb(1, M_RSUB, 2); in_data = rep_in(1'b0, 64'd1);  tick();
    check_eq("sub_m7", dout, rep_out(8'hFF, 64'hFFFF_FFFF_FFFF_FFF9));
    idle(); in_valid = 1'b0; tick();
    check_eq("rsub_m8", dout, rep_out(8'hFF, 64'hFFFF_FFFF_FFFF_FFF8));

    // NEG of zero, then accumulate carry-max until overflow, then CLR
    idle(); setb(2, M_CLR, 0); tick();
    idle(); outsel = 2'd2; setb(2, M_NEG, 0); tick();
    idle(); in_valid = 1'b0; tick();
    check_eq("neg_mod", dout, mod_out);
    for (int n = 0; n < 300; n++) begin
      idle(); outsel = 2'd2; setb(2, (n % 2 == 0) ? M_ADD : M_ADD2, 0);
      in_data = rep_in(1'b1, all1); tick();
    end
    check_eq("ovf_sticky", DW'(ovf[2]), DW'(1));
    idle(); setb(2, M_CLR, 0); tick();
    check_eq("ovf_clr", DW'(ovf[2]), DW'(0));
    idle(); outsel = 2'd2; tick();
    idle(); in_valid = 1'b0; tick();
    check_eq("clr_zero", dout, '0);

    // Thread isolation at a1 across all banks
    for (int t = 0; t < THREADS; t++) begin
      idle(); thread = 2'(t);
      for (int k = 0; k < NACC; k++) setb(k, M_LOAD, 1);
      in_data = rep_in(1'b0, 64'(t + 1)); tick();
    end
    repeat (3) begin
      idle(); in_valid = 1'b0; thread = 2'($urandom_range(0, 3));
      for (int k = 0; k < NACC; k++) setb(k, $urandom_range(1, 7), 1);
      in_data = rep_in(1'b1, 64'($urandom)); tick();
    end
    for (int t = 0; t < THREADS; t++) begin
      for (int k = 0; k < NACC; k++) begin
        idle(); thread = 2'(t); outsel = 2'(k);
        for (int j = 0; j < NACC; j++) setb(j, M_NOP, 1);
        tick();
        idle(); in_valid = 1'b0; tick();
        check_eq("thread_iso", dout, rep_out(8'h00, 64'(t + 1)));
      end
    end

    // Out-of-range address and bank select
    idle(); setb(0, M_ADD, 3); in_data = rep_in(1'b0, 64'd9); tick();
    idle(); in_valid = 1'b0; tick();
    check_eq("oor_addr", dout, rep_out(8'h00, 64'd9));
    idle(); outsel = 2'd3; setb(0, M_LOAD, 0); in_data = rep_in(1'b0, 64'd9); tick();
    idle(); in_valid = 1'b0; tick();
    check_eq("oor_sel", dout, '0);
    check_eq("oor_sel_v", DW'(dout_valid), DW'(1));

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NACC; k++) setb(k, $urandom_range(0, 7), $urandom_range(0, 3));
      thread = 2'($urandom_range(0, 3));
      outsel = 2'($urandom_range(0, 3));
      for (int i = 0; i < LIMBS; i++) begin
        rv64 = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) rv64 = all1;
        in_data[i*IW +: IW] = {1'($urandom_range(0, 1)), rv64};
      end
      tick();
    end

    // Reset between two valid inputs, with an overflow pending on bank1
    idle(); setb(1, M_CLR, 0); tick();
    for (int n = 0; n < 70; n++) begin
      idle(); setb(1, M_ADD, 0); in_data = rep_in(1'b1, all1); tick();
    end
    check_eq("ovf_pre_rst", DW'(ovf[1]), DW'(1));
    idle(); setb(0, M_LOAD, 2); in_data = rep_in(1'b0, 64'd5); tick();
    idle(); setb(0, M_ADD, 2);  in_data = rep_in(1'b0, 64'd1); tick();
    #2 rstn = 1'b0;
    #1;
    check_eq("mid_rst_dout", dout, '0);
    check_eq("mid_rst_valid", DW'(dout_valid), '0);
    check_eq("mid_rst_ovf", DW'(ovf), '0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    idle(); setb(0, M_NOP, 2); tick();
    idle(); in_valid = 1'b0; tick();
    check_eq("rst_entry", dout, '0);
    check_eq("rst_entry_v", DW'(dout_valid), DW'(1));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
